// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The divider takes the slave view; the controlling logic takes the master view.
interface clk_div_prog_if #(
  parameter int unsigned W = 8
);
  logic         en;
  logic [W-1:0] div_ratio;
  logic         ratio_load;
  logic         clk_tx;
  logic         tick;
  logic [W-1:0] ratio_act;
  logic         ratio_err;

  modport master (
    output en, div_ratio, ratio_load,
    input  clk_tx, tick, ratio_act, ratio_err
  );

  modport slave (
    input  en, div_ratio, ratio_load,
    output clk_tx, tick, ratio_act, ratio_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer divider of clk_rx with glitch-free ratio/enable changes
// at period boundaries, optional 50% duty for odd ratios, and a clk_rx-domain tick.
module clk_div_prog #(
  parameter int unsigned W           = 8,
  parameter int unsigned DEFAULT_DIV = 2,
  parameter bit          ODD_50      = 1'b1
) (
  input logic           clk_rx,
  input logic           rst_n,
  clk_div_prog_if.slave bus
);

  localparam logic [W-1:0] DefRatio = W'(DEFAULT_DIV);
  localparam logic [W-1:0] One      = W'(1);
  localparam logic [W-1:0] Two      = W'(2);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] ratio_q, ratio_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         h_q, h_d;
  logic         h_n_q;
  logic         tick_q, tick_d;
  logic         pending_q, pending_d;
  logic         err_q, err_d;

  logic [W-1:0] half;
  logic [W-1:0] last;
  logic [W-1:0] cnt_inc;
  logic         at_end;
  logic         boundary;
  logic         load_ok;
  logic         odd_ceil;

  // High time: floor(N/2) when the negedge helper adds the extra half cycle, else ceil(N/2).
  assign odd_ceil = ratio_q[0] & ~ODD_50;
  assign half     = (ratio_q >> 1) + W'(odd_ceil);
  assign last     = ratio_q - One;
  assign cnt_inc  = cnt_q + One;
  assign at_end   = (cnt_q == last);
  assign boundary = bus.en && ((state_q == StIdle) || at_end);
  assign load_ok  = bus.ratio_load && (bus.div_ratio >= Two);

  always_ff @(posedge clk_rx) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.en) state_d = StRun;
      StRun:   if (at_end && !bus.en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    h_d       = h_q;
    tick_d    = 1'b0;
    ratio_d   = ratio_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        h_d    = bus.en;
        tick_d = bus.en;
      end
      StRun: begin
        if (!at_end) begin
          cnt_d = cnt_inc;
          h_d   = (cnt_inc < half);
        end else begin
          cnt_d  = '0;
          h_d    = bus.en;
          tick_d = bus.en;
        end
      end
      default: begin
        cnt_d = '0;
        h_d   = 1'b0;
      end
    endcase

    // Boundary commits the shadow as it stood before this cycle's load.
    if (boundary && pending_q) begin
      ratio_d   = shadow_q;
      pending_d = 1'b0;
    end

    if (bus.ratio_load) begin
      if (load_ok) begin
        shadow_d  = bus.div_ratio;
        pending_d = 1'b1;
        err_d     = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_rx) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      h_q       <= 1'b0;
      tick_q    <= 1'b0;
      ratio_q   <= DefRatio;
      shadow_q  <= DefRatio;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      h_q       <= h_d;
      tick_q    <= tick_d;
      ratio_q   <= ratio_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Half-cycle extension of h for odd ratios.
  always_ff @(negedge clk_rx) begin
    if (!rst_n) begin
      h_n_q <= 1'b0;
    end else begin
      h_n_q <= h_q;
    end
  end

  assign bus.clk_tx    = h_q | (ODD_50 & ratio_q[0] & h_n_q);
  assign bus.tick      = tick_q;
  assign bus.ratio_act = ratio_q;
  assign bus.ratio_err = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: one instance with odd-ratio 50% duty, one without,
// both driven with identical stimulus.
module tb_clk_div_prog;

  logic clk_rx;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [31:0] p1, n1, t1, p0, n0, t0;

  clk_div_prog_if #(.W(8)) bus1 ();
  clk_div_prog_if #(.W(8)) bus0 ();

  clk_div_prog #(.W(8), .DEFAULT_DIV(2), .ODD_50(1'b1)) u_dut (
    .clk_rx (clk_rx),
    .rst_n  (rst_n),
    .bus    (bus1)
  );

  clk_div_prog #(.W(8), .DEFAULT_DIV(2), .ODD_50(1'b0)) u_dut_nohalf (
    .clk_rx (clk_rx),
    .rst_n  (rst_n),
    .bus    (bus0)
  );

  initial clk_rx = 1'b0;
  always #5 clk_rx = ~clk_rx;

  task automatic step();
    @(posedge clk_rx);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [7:0] ratio, input logic load);
    bus1.en = en;  bus1.div_ratio = ratio;  bus1.ratio_load = load;
    bus0.en = en;  bus0.div_ratio = ratio;  bus0.ratio_load = load;
  endtask

  // Bit i of each vector: cycle i sampled just after posedge (p, t) and after negedge (n).
  task automatic capture(input int n, output logic [31:0] cp1, output logic [31:0] cn1,
                         output logic [31:0] ct1, output logic [31:0] cp0,
                         output logic [31:0] cn0, output logic [31:0] ct0);
    cp1 = '0; cn1 = '0; ct1 = '0; cp0 = '0; cn0 = '0; ct0 = '0;
    for (int i = 0; i < n; i++) begin
      cp1[i] = bus1.clk_tx;
      ct1[i] = bus1.tick;
      cp0[i] = bus0.clk_tx;
      ct0[i] = bus0.tick;
      @(negedge clk_rx);
      #1;
      cn1[i] = bus1.clk_tx;
      cn0[i] = bus0.clk_tx;
      step();
    end
  endtask

  task automatic wait_tick(input string tag);
    for (int i = 0; i < 16 && bus1.tick !== 1'b1; i++) step();
    chk(tag, 32'(bus1.tick), 32'd1);
    chk({tag, "_b"}, 32'(bus0.tick), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 8'd0, 1'b0);
    repeat (3) step();

    chk("rst_clk_tx",   32'(bus1.clk_tx),    32'd0);
    chk("rst_tick",     32'(bus1.tick),      32'd0);
    chk("rst_ratio",    32'(bus1.ratio_act), 32'd2);
    chk("rst_err",      32'(bus1.ratio_err), 32'd0);
    chk("rst_clk_tx_b", 32'(bus0.clk_tx),    32'd0);

    // Default divide-by-2, first rise at the posedge sampling en
    rst_n = 1'b1;
    drive(1'b1, 8'd0, 1'b0);
    step();
    capture(4, p1, n1, t1, p0, n0, t0);
    chk("t1_pos",   p1, 32'h5);
    chk("t1_neg",   n1, 32'h5);
    chk("t1_tick",  t1, 32'h5);
    chk("t1_pos_b", p0, 32'h5);
    chk("t1_ratio", 32'(bus1.ratio_act), 32'd2);

    // Ratio 6 applies only at the next boundary
    drive(1'b1, 8'd6, 1'b1);
    step();
    drive(1'b1, 8'd6, 1'b0);
    chk("t2_ratio_before", 32'(bus1.ratio_act), 32'd2);
    chk("t2_low",          32'(bus1.clk_tx),    32'd0);
    step();
    chk("t2_ratio_after",  32'(bus1.ratio_act), 32'd6);
    capture(12, p1, n1, t1, p0, n0, t0);
    chk("t2_pos",   p1, 32'h1C7);
    chk("t2_neg",   n1, 32'h1C7);
    chk("t2_tick",  t1, 32'h041);
    chk("t2_pos_b", p0, 32'h1C7);

    // Ratio 5: 2.5/2.5 with helper, 3/2 without
    drive(1'b1, 8'd5, 1'b1);
    step();
    drive(1'b1, 8'd5, 1'b0);
    wait_tick("t3_boundary");
    chk("t3_ratio",   32'(bus1.ratio_act), 32'd5);
    chk("t3_ratio_b", 32'(bus0.ratio_act), 32'd5);
    capture(10, p1, n1, t1, p0, n0, t0);
    chk("t3_pos",    p1, 32'hE7);
    chk("t3_neg",    n1, 32'h63);
    chk("t3_tick",   t1, 32'h21);
    chk("t3_pos_b",  p0, 32'hE7);
    chk("t3_neg_b",  n0, 32'hE7);
    chk("t3_tick_b", t0, 32'h21);

    // Ratio 8, then loads of 3 and 4 mid-period: last write wins at the boundary
    drive(1'b1, 8'd8, 1'b1);
    step();
    drive(1'b1, 8'd8, 1'b0);
    wait_tick("t4_to8");
    chk("t4_ratio8", 32'(bus1.ratio_act), 32'd8);
    step();
    step();
    chk("t4_high_mid", 32'(bus1.clk_tx), 32'd1);
    drive(1'b1, 8'd3, 1'b1);
    step();
    chk("t4_high_mid2", 32'(bus1.clk_tx), 32'd1);
    drive(1'b1, 8'd4, 1'b1);
    step();
    drive(1'b1, 8'd4, 1'b0);
    chk("t4_ratio_hold", 32'(bus1.ratio_act), 32'd8);
    capture(12, p1, n1, t1, p0, n0, t0);
    chk("t4_pos",   p1, 32'h330);
    chk("t4_neg",   n1, 32'h330);
    chk("t4_tick",  t1, 32'h110);
    chk("t4_pos_b", p0, 32'h330);
    chk("t4_ratio4", 32'(bus1.ratio_act), 32'd4);

    // Illegal loads set the sticky error and leave the ratio alone
    drive(1'b1, 8'd0, 1'b1);
    step();
    chk("t5_err_0", 32'(bus1.ratio_err), 32'd1);
    drive(1'b1, 8'd1, 1'b1);
    step();
    drive(1'b1, 8'd1, 1'b0);
    chk("t5_err_1",   32'(bus1.ratio_err), 32'd1);
    chk("t5_ratio_a", 32'(bus1.ratio_act), 32'd4);
    wait_tick("t5_bnd1");
    chk("t5_ratio_b", 32'(bus1.ratio_act), 32'd4);
    drive(1'b1, 8'd7, 1'b1);
    step();
    drive(1'b1, 8'd7, 1'b0);
    chk("t5_err_clr", 32'(bus1.ratio_err), 32'd0);
    chk("t5_ratio_c", 32'(bus1.ratio_act), 32'd4);
    wait_tick("t5_bnd2");
    chk("t5_ratio7",  32'(bus1.ratio_act), 32'd7);

    // Ratio 10, drop en at cnt=2: period completes, then stays low
    drive(1'b1, 8'd10, 1'b1);
    step();
    drive(1'b1, 8'd10, 1'b0);
    wait_tick("t6_to10");
    chk("t6_ratio10", 32'(bus1.ratio_act), 32'd10);
    step();
    step();
    drive(1'b0, 8'd10, 1'b0);
    capture(10, p1, n1, t1, p0, n0, t0);
    chk("t6_pos",   p1, 32'h007);
    chk("t6_neg",   n1, 32'h007);
    chk("t6_tick",  t1, 32'h000);
    chk("t6_pos_b", p0, 32'h007);

    // Restart, then reset at cnt=4
    drive(1'b1, 8'd10, 1'b0);
    step();
    chk("t6_restart_tick", 32'(bus1.tick),   32'd1);
    chk("t6_restart_clk",  32'(bus1.clk_tx), 32'd1);
    drive(1'b1, 8'd0, 1'b1);
    step();
    drive(1'b1, 8'd0, 1'b0);
    chk("t6_err_set", 32'(bus1.ratio_err), 32'd1);
    step();
    step();
    step();
    chk("t6_pre_rst", 32'(bus1.clk_tx), 32'd1);
    rst_n = 1'b0;
    step();
    chk("t6_rst_clk",     32'(bus1.clk_tx),    32'd0);
    chk("t6_rst_tick",    32'(bus1.tick),      32'd0);
    chk("t6_rst_ratio",   32'(bus1.ratio_act), 32'd2);
    chk("t6_rst_err",     32'(bus1.ratio_err), 32'd0);
    chk("t6_rst_ratio_b", 32'(bus0.ratio_act), 32'd2);
    rst_n = 1'b1;
    drive(1'b0, 8'd0, 1'b0);
    step();
    step();
    chk("t6_idle_clk",  32'(bus1.clk_tx), 32'd0);
    chk("t6_idle_tick", 32'(bus1.tick),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
